// File: rtl/vga_pkg.sv
// Shared definitions for the VGA grid display.
// Holds the 640x480@60 timing defaults, the board-cell encodings, the 8-bit
// RRRGGGBB colour constants and a small helper that selects one cell from the
// packed 9-cell board vector.
package vga_pkg;

    // Counter width for hc/vc; wide enough for the 800x521 default raster.
    localparam int unsigned CNT_W = 10;

    // 640x480 horizontal timing, in pixels.
    localparam int unsigned H_PULSE_DEF    = 96;
    localparam int unsigned H_BP_END_DEF   = 144;
    localparam int unsigned H_FP_START_DEF = 784;
    localparam int unsigned H_TOTAL_DEF    = 800;

    // 640x480 vertical timing, in lines.
    localparam int unsigned V_PULSE_DEF    = 2;
    localparam int unsigned V_BP_END_DEF   = 31;
    localparam int unsigned V_FP_START_DEF = 511;
    localparam int unsigned V_TOTAL_DEF    = 521;

    // Grid geometry, in active-area pixels.
    localparam int unsigned GRID_X0_DEF = 80;
    localparam int unsigned GRID_Y0_DEF = 0;
    localparam int unsigned CELL_PX_DEF = 160;
    localparam int unsigned LINE_W_DEF  = 10;
    localparam int unsigned MARGIN_DEF  = 20;

    // Two-bit cell contents; the reserved code renders as empty.
    typedef enum logic [1:0] {
        CellEmpty = 2'b00,
        CellX     = 2'b01,
        CellO     = 2'b10,
        CellRsvd  = 2'b11
    } cell_e;

    // Colour packed as {red[2:0], green[2:0], blue[1:0]}.
    typedef logic [7:0] rgb_t;

    localparam rgb_t COL_BLACK  = 8'b000_000_00;
    localparam rgb_t COL_WHITE  = 8'b111_111_11;
    localparam rgb_t COL_RED    = 8'b111_000_00;
    localparam rgb_t COL_BLUE   = 8'b000_000_11;
    localparam rgb_t COL_YELLOW = 8'b111_111_00;

    // Select cell k (0..8) from the row-major board; out-of-range k reads empty.
    function automatic cell_e cell_at(input logic [17:0] board, input logic [3:0] k);
        cell_e v;
        v = CellEmpty;
        for (int i = 0; i < 9; i++) begin
            if (k == 4'(i)) begin
                v = cell_e'(board[2*i +: 2]);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing generator.
// Counts hc/vc on pixel strobes and decodes the raw (unregistered) sync levels,
// the active-video window and the end-of-line / end-of-frame strobes.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   pix_en        one-cycle pixel strobe; counters advance only when set
//   hc, vc        current pixel/line position
//   hsync_raw     low while hc < H_PULSE
//   vsync_raw     low while vc < V_PULSE
//   active        current position lies in the visible area
//   line_end      hc is the last pixel of the line
//   frame_end     hc/vc is the last pixel of the frame
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_PULSE    = H_PULSE_DEF,
    parameter int unsigned H_BP_END   = H_BP_END_DEF,
    parameter int unsigned H_FP_START = H_FP_START_DEF,
    parameter int unsigned H_TOTAL    = H_TOTAL_DEF,
    parameter int unsigned V_PULSE    = V_PULSE_DEF,
    parameter int unsigned V_BP_END   = V_BP_END_DEF,
    parameter int unsigned V_FP_START = V_FP_START_DEF,
    parameter int unsigned V_TOTAL    = V_TOTAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             active,
    output logic             line_end,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    always_comb begin
        line_end  = (hc_q == H_LAST);
        frame_end = line_end && (vc_q == V_LAST);
    end

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (line_end) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
            end else begin
                hc_d = hc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    always_comb begin
        hsync_raw = !(hc_q < CNT_W'(H_PULSE));
        vsync_raw = !(vc_q < CNT_W'(V_PULSE));
        active    = (hc_q >= CNT_W'(H_BP_END)) && (hc_q < CNT_W'(H_FP_START)) &&
                    (vc_q >= CNT_W'(V_BP_END)) && (vc_q < CNT_W'(V_FP_START));
    end

    assign hc = hc_q;
    assign vc = vc_q;

endmodule

// File: rtl/vga_grid_display.sv
// Tic-tac-toe board renderer for a VGA raster.
// Draws a 3x3 grid with X marks in red, O marks in blue and the empty cursor
// cell in yellow. Board and cursor are shadowed once per frame so a frame is
// always rendered from one consistent snapshot. Sync and colour are registered
// together on the pixel strobe, one pixel behind the timing counters.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pix_en              one-cycle pixel strobe
//   cells[17:0]         board, cell k at [2k+1:2k], row-major
//   cursor[3:0]         highlighted cell 0..8, 9..15 = none
//   hsync, vsync        registered, active-low sync
//   red, green, blue    registered colour (3/3/2 bits)
//   frame_start         one-clk pulse after the board snapshot is taken
module vga_grid_display
    import vga_pkg::*;
#(
    parameter int unsigned H_PULSE    = H_PULSE_DEF,
    parameter int unsigned H_BP_END   = H_BP_END_DEF,
    parameter int unsigned H_FP_START = H_FP_START_DEF,
    parameter int unsigned H_TOTAL    = H_TOTAL_DEF,
    parameter int unsigned V_PULSE    = V_PULSE_DEF,
    parameter int unsigned V_BP_END   = V_BP_END_DEF,
    parameter int unsigned V_FP_START = V_FP_START_DEF,
    parameter int unsigned V_TOTAL    = V_TOTAL_DEF,
    parameter int unsigned GRID_X0    = GRID_X0_DEF,
    parameter int unsigned GRID_Y0    = GRID_Y0_DEF,
    parameter int unsigned CELL_PX    = CELL_PX_DEF,
    parameter int unsigned LINE_W     = LINE_W_DEF,
    parameter int unsigned MARGIN     = MARGIN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [17:0] cells,
    input  logic [3:0]  cursor,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        frame_start
);

    // Grid bounds expressed directly in hc/vc so no subtraction is needed.
    localparam logic [CNT_W-1:0] GX_START  = CNT_W'(H_BP_END + GRID_X0);
    localparam logic [CNT_W-1:0] GX_END    = CNT_W'(H_BP_END + GRID_X0 + 3 * CELL_PX);
    localparam logic [CNT_W-1:0] GY_START  = CNT_W'(V_BP_END + GRID_Y0);
    localparam logic [CNT_W-1:0] GY_END    = CNT_W'(V_BP_END + GRID_Y0 + 3 * CELL_PX);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(CELL_PX - 1);
    localparam logic [CNT_W-1:0] LINE_FROM = CNT_W'(CELL_PX - LINE_W);
    localparam logic [CNT_W-1:0] MARK_LO   = CNT_W'(MARGIN);
    localparam logic [CNT_W-1:0] MARK_HI   = CNT_W'(CELL_PX - LINE_W - MARGIN);

    logic [CNT_W-1:0] hc, vc;
    logic             hsync_raw, vsync_raw, active, line_end, frame_end;

    vga_timing #(
        .H_PULSE    (H_PULSE),
        .H_BP_END   (H_BP_END),
        .H_FP_START (H_FP_START),
        .H_TOTAL    (H_TOTAL),
        .V_PULSE    (V_PULSE),
        .V_BP_END   (V_BP_END),
        .V_FP_START (V_FP_START),
        .V_TOTAL    (V_TOTAL)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .hc        (hc),
        .vc        (vc),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .active    (active),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // ------------------------------------------------------------------
    // Incremental cell tracking. The registers always describe the pixel
    // currently addressed by hc/vc, so they are reloaded when the *next*
    // position is the grid origin. Indices saturate at 3 (= past the grid);
    // outside the grid the values are don't-care and masked by in_grid.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] hc_next, vc_next;
    logic [CNT_W-1:0] col_off_q, col_off_d, row_off_q, row_off_d;
    logic [1:0]       col_idx_q, col_idx_d, row_idx_q, row_idx_d;

    always_comb begin
        hc_next = line_end ? '0 : hc + CNT_W'(1);
        vc_next = (vc == V_LAST) ? '0 : vc + CNT_W'(1);
    end

    always_comb begin
        col_off_d = col_off_q;
        col_idx_d = col_idx_q;
        if (pix_en) begin
            if (hc_next == GX_START) begin
                col_off_d = '0;
                col_idx_d = '0;
            end else if (col_off_q == CELL_LAST) begin
                col_off_d = '0;
                if (col_idx_q != 2'd3) begin
                    col_idx_d = col_idx_q + 2'd1;
                end
            end else begin
                col_off_d = col_off_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        row_off_d = row_off_q;
        row_idx_d = row_idx_q;
        if (pix_en && line_end) begin
            if (vc_next == GY_START) begin
                row_off_d = '0;
                row_idx_d = '0;
            end else if (row_off_q == CELL_LAST) begin
                row_off_d = '0;
                if (row_idx_q != 2'd3) begin
                    row_idx_d = row_idx_q + 2'd1;
                end
            end else begin
                row_off_d = row_off_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel classification and colour selection.
    // ------------------------------------------------------------------
    logic [17:0] shadow_cells_q;
    logic [3:0]  shadow_cursor_q;
    logic        in_grid, line_px, mark_px, cursor_hit, cell_is_empty;
    logic [3:0]  cell_k;
    cell_e       cell_v;
    rgb_t        pix_rgb;

    always_comb begin
        in_grid = (hc >= GX_START) && (hc < GX_END) && (vc >= GY_START) && (vc < GY_END);

        // Only the two interior lines per axis are drawn; no outer border.
        line_px = in_grid &&
                  (((col_off_q >= LINE_FROM) && (col_idx_q < 2'd2)) ||
                   ((row_off_q >= LINE_FROM) && (row_idx_q < 2'd2)));

        mark_px = in_grid && !line_px &&
                  (col_off_q >= MARK_LO) && (col_off_q < MARK_HI) &&
                  (row_off_q >= MARK_LO) && (row_off_q < MARK_HI);

        // k = 3*row + col, built from a shift and adds.
        cell_k = {1'b0, row_idx_q, 1'b0} + {2'b00, row_idx_q} + {2'b00, col_idx_q};
        cell_v = cell_at(shadow_cells_q, cell_k);

        cell_is_empty = (cell_v == CellEmpty) || (cell_v == CellRsvd);
        cursor_hit    = in_grid && !line_px && cell_is_empty && (shadow_cursor_q == cell_k);
    end

    always_comb begin
        pix_rgb = COL_BLACK;
        if (!active) begin
            pix_rgb = COL_BLACK;
        end else if (line_px) begin
            pix_rgb = COL_WHITE;
        end else if (mark_px && (cell_v == CellX)) begin
            pix_rgb = COL_RED;
        end else if (mark_px && (cell_v == CellO)) begin
            pix_rgb = COL_BLUE;
        end else if (cursor_hit) begin
            pix_rgb = COL_YELLOW;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    logic hsync_q, vsync_q, frame_start_q;
    rgb_t rgb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_off_q       <= '0;
            col_idx_q       <= '0;
            row_off_q       <= '0;
            row_idx_q       <= '0;
            shadow_cells_q  <= '0;
            shadow_cursor_q <= 4'hF;
            hsync_q         <= 1'b1;
            vsync_q         <= 1'b1;
            rgb_q           <= COL_BLACK;
            frame_start_q   <= 1'b0;
        end else begin
            col_off_q     <= col_off_d;
            col_idx_q     <= col_idx_d;
            row_off_q     <= row_off_d;
            row_idx_q     <= row_idx_d;
            // Strobe is one clk wide, so this flag is a one-clk pulse.
            frame_start_q <= pix_en && frame_end;
            if (pix_en) begin
                hsync_q <= hsync_raw;
                vsync_q <= vsync_raw;
                rgb_q   <= pix_rgb;
            end
            // Snapshot on the last pixel so the whole next frame sees one board.
            if (pix_en && frame_end) begin
                shadow_cells_q  <= cells;
                shadow_cursor_q <= cursor;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q[7:5];
    assign green       = rgb_q[4:2];
    assign blue        = rgb_q[1:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_grid_display.sv
// Directed self-checking bench for vga_grid_display, using a shrunken raster
// (70x60 total, 56x52 active) and 16-pixel cells so several frames fit in a
// short run. Geometry: grid origin x=4, cell pitch 16, line width 2, margin 3,
// so line offsets are 14..15 and mark offsets are 3..10 inside each cell.
module tb_vga_grid_display;

    localparam int HP = 4,  HB = 8,  HF = 64, HT = 70;
    localparam int VP = 2,  VB = 4,  VF = 56, VT = 60;
    localparam int GX = 4,  GY = 0,  CP = 16, LW = 2, MG = 3;

    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] WHT = 8'hFF;
    localparam logic [7:0] RED = 8'hE0;
    localparam logic [7:0] BLU = 8'h03;
    localparam logic [7:0] YEL = 8'hFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [17:0] cells = '0;
    logic [3:0]  cursor = 4'hF;
    logic        hsync, vsync, frame_start;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic [7:0]  rgb;

    assign rgb = {red, green, blue};

    vga_grid_display #(
        .H_PULSE    (HP),
        .H_BP_END   (HB),
        .H_FP_START (HF),
        .H_TOTAL    (HT),
        .V_PULSE    (VP),
        .V_BP_END   (VB),
        .V_FP_START (VF),
        .V_TOTAL    (VT),
        .GRID_X0    (GX),
        .GRID_Y0    (GY),
        .CELL_PX    (CP),
        .LINE_W     (LW),
        .MARGIN     (MG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .cells       (cells),
        .cursor      (cursor),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    // th/tv: counter position the DUT renders next; lh/lv: pixel now on outputs.
    int th = 0, tv = 0, lh = -1, lv = -1;
    int fs_count = 0;
    int hs_low = 0, vs_low = 0;

    // frame_start is high for one full clk, so it is seen at exactly one edge.
    always @(posedge clk) begin
        if (frame_start) fs_count++;
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One pixel strobe; outputs are sampled at the following falling edge.
    task automatic strobe();
        @(negedge clk) pix_en = 1'b1;
        @(negedge clk) pix_en = 1'b0;
        lh = th;
        lv = tv;
        if (th == HT - 1) begin
            th = 0;
            tv = (tv == VT - 1) ? 0 : tv + 1;
        end else begin
            th++;
        end
    endtask

    task automatic goto_hv(input int h, input int v);
        int n;
        n = 0;
        do begin
            strobe();
            n++;
        end while (!(lh == h && lv == v) && n < HT * VT + 2);
        if (!(lh == h && lv == v)) begin
            miscompares++;
            $display("FAIL goto: observed position %0d,%0d, expected %0d,%0d", lh, lv, h, v);
            $fatal(1, "position tracking lost");
        end
    endtask

    task automatic check_px(input string tag, input int x, input int y, input logic [7:0] exp);
        goto_hv(x + HB, y + VB);
        check8(tag, rgb, exp);
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check8("rst_hsync", {7'b0, hsync}, 8'h01);
        check8("rst_vsync", {7'b0, vsync}, 8'h01);
        check8("rst_rgb", rgb, BLK);
        check8("rst_fs", {7'b0, frame_start}, 8'h00);
        rst = 1'b0;

        // Frame 0: sync waveform over a full frame
        for (int i = 0; i < HT * VT; i++) begin
            strobe();
            check8("f0_hsync", {7'b0, hsync}, (lh >= HP) ? 8'h01 : 8'h00);
            check8("f0_vsync", {7'b0, vsync}, (lv >= VP) ? 8'h01 : 8'h00);
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
        end
        repeat (2) @(negedge clk);
        check8("f0_hs_low_total", 8'(hs_low / 4), 8'(HP * VT / 4));
        check8("f0_vs_low_total", 8'(vs_low / 4), 8'(VP * HT / 4));
        check8("f0_fs_count", 8'(fs_count), 8'd1);

        // Frame 1: board still the reset snapshot; new inputs wait for next frame
        cells  = 18'h00009;  // cell0 = X, cell1 = O
        cursor = 4'd4;
        check_px("f1_outside_x",   3,  5, BLK);
        check_px("f1_shadow_c0",  10,  5, BLK);
        check_px("f1_col0_off13", 17,  5, BLK);
        check_px("f1_col0_line",  18,  5, WHT);
        check_px("f1_col0_line2", 19,  5, WHT);
        check_px("f1_col1_off0",  20,  5, BLK);
        check_px("f1_shadow_c1",  26,  5, BLK);
        check_px("f1_col1_line",  34,  5, WHT);
        check_px("f1_col2_noline", 50, 5, BLK);
        check_px("f1_row0_off13", 10, 13, BLK);
        check_px("f1_row0_line",  10, 14, WHT);
        check_px("f1_row0_line2", 10, 15, WHT);
        check_px("f1_row1_off0",  10, 16, BLK);
        check_px("f1_no_cursor",  24, 20, BLK);
        check_px("f1_below_grid", 10, 48, BLK);

        // Frame 2: X in cell0, O in cell1, cursor on empty cell4
        check_px("f2_row_off2",   10,  2, BLK);
        check_px("f2_row_off3",   10,  3, RED);
        check_px("f2_col_off2",    6,  5, BLK);
        check_px("f2_col_off3",    7,  5, RED);
        check_px("f2_mark_x",     10,  5, RED);
        check_px("f2_col_off10",  14,  5, RED);
        check_px("f2_col_off11",  15,  5, BLK);
        check_px("f2_mark_o",     26,  5, BLU);
        check_px("f2_cursor_edge", 21, 17, YEL);
        check_px("f2_cursor_mid", 24, 20, YEL);
        check_px("f2_cursor_line", 34, 20, WHT);
        cells = 18'h00109;   // cell4 = X, visible only from next frame
        check_px("f2_tear_hold",  24, 22, YEL);

        // Frame 3: cell4 now holds X
        check_px("f3_mark_x",     10,  5, RED);
        check_px("f3_cur_x_edge", 21, 17, BLK);
        check_px("f3_cur_x_mark", 24, 20, RED);

        // Frame 4: mid-frame reset while both syncs are low
        goto_hv(2, 1);
        check8("f4_pre_hsync", {7'b0, hsync}, 8'h00);
        check8("f4_pre_vsync", {7'b0, vsync}, 8'h00);
        check8("fs_before_rst", 8'(fs_count), 8'd4);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        th = 0;
        tv = 0;
        check8("mid_rst_hsync", {7'b0, hsync}, 8'h01);
        check8("mid_rst_vsync", {7'b0, vsync}, 8'h01);
        check8("mid_rst_rgb", rgb, BLK);
        strobe();
        check8("restart_hsync", {7'b0, hsync}, 8'h00);
        check8("restart_vsync", {7'b0, vsync}, 8'h00);
        check_px("restart_shadow", 10, 5, BLK);
        check_px("restart_line",   19, 5, WHT);

        // pix_en held low: outputs and position must not move
        repeat (50) @(negedge clk);
        check8("hold_rgb", rgb, WHT);
        check8("hold_hsync", {7'b0, hsync}, 8'h01);
        check8("hold_vsync", {7'b0, vsync}, 8'h01);
        strobe();
        check8("after_hold1", rgb, BLK);  // x=20
        check_px("hold2_pre", 33, 5, BLK);
        repeat (50) @(negedge clk);
        strobe();
        check8("after_hold2", rgb, WHT);  // x=34, col1 line
        check8("fs_after_rst", 8'(fs_count), 8'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_grid_display.md
VGA_GRID_DISPLAY -- requirements
Module: vga_grid_display

Interface
REQ-001 SHALL have parameter H_PULSE, default 96: hsync low width, in pixels.
REQ-002 SHALL have parameter H_BP_END, default 144: first active hc.
REQ-003 SHALL have parameter H_FP_START, default 784: first inactive hc after the active region.
REQ-004 SHALL have parameter H_TOTAL, default 800: pixels per line.
REQ-005 SHALL have parameters V_PULSE, V_BP_END, V_FP_START and V_TOTAL, defaults 2, 31, 511 and 521: the vertical equivalents, in lines.
REQ-006 SHALL have parameters GRID_X0 and GRID_Y0, defaults 80 and 0: grid origin, in active-area coordinates.
REQ-007 SHALL have parameter CELL_PX, default 160: cell pitch, including the line.
REQ-008 SHALL have parameter LINE_W, default 10: grid line thickness.
REQ-009 SHALL have parameter MARGIN, default 20: mark inset within a cell.
REQ-010 SHALL have port clk, input, 1 bit: 100 MHz system clock.
REQ-011 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-012 SHALL have port pix_en, input, 1 bit: one-cycle pixel strobe, 25 MHz.
REQ-013 SHALL have port cells, input, 18 bits: 9 cells × 2 bits, cell k at [2k+1:2k], row-major; 00 = empty, 01 = X, 10 = O, 11 = reserved (treated as empty).
REQ-014 SHALL have port cursor, input, 4 bits: highlighted cell 0..8; values 9..15 mean no highlight.
REQ-015 SHALL have port hsync, output, 1 bit: registered, active low.
REQ-016 SHALL have port vsync, output, 1 bit: registered, active low.
REQ-017 SHALL have ports red, green and blue, outputs of 3, 3 and 2 bits: registered colour.
REQ-018 SHALL have port frame_start, output, 1 bit: one-clk pulse.

Function
REQ-019 hc SHALL advance only on cycles where pix_en=1, counting 0..H_TOTAL-1 and then wrapping to 0; vc SHALL increment at each hc wrap and itself wrap from V_TOTAL-1 to 0.
REQ-020 Raw sync SHALL be low when hc<H_PULSE (hsync) or vc<V_PULSE (vsync).
REQ-021 The pixel is active when H_BP_END≤hc<H_FP_START and V_BP_END≤vc<V_FP_START; active coordinates are x=hc-H_BP_END and y=vc-V_BP_END.
REQ-022 Cell column and row SHALL be tracked incrementally with an in-cell offset counter and a col/row index; no divider or modulo hardware is allowed.
REQ-023 The column offset SHALL reset to 0 at x=GRID_X0 and the column index SHALL advance each time the offset reaches CELL_PX-1; the row counters behave identically at y=GRID_Y0, advancing once per line.
REQ-024 A pixel is inside the grid when GRID_X0≤x<GRID_X0+3·CELL_PX and likewise for y.
REQ-025 A pixel is a grid line when it is inside the grid and either: col offset≥CELL_PX-LINE_W with col<2, or row offset≥CELL_PX-LINE_W with row<2.
REQ-026 A pixel is a mark pixel when it is inside the grid, not a line, and both offsets lie in [MARGIN, CELL_PX-LINE_W-MARGIN).
REQ-027 Colour priority SHALL be as follows, highest first:
- inactive → 000/000/00
- grid line → white 111/111/11
- mark pixel in a cell holding X → red 111/000/00
- mark pixel in a cell holding O → blue 000/000/11
- any non-line pixel of the cursor cell when that cell is empty → yellow 111/111/00
- otherwise → black
REQ-028 Frame shadowing: cells and cursor SHALL be sampled into shadow registers only on the pix_en cycle where hc=H_TOTAL-1 and vc=V_TOTAL-1; rendering SHALL use the shadow copies only, so no mid-frame tearing occurs.
REQ-029 frame_start SHALL pulse for exactly one clk, in the cycle after that shadow load.
REQ-030 hsync, vsync and RGB SHALL all update only on pix_en cycles, with exactly one pixel of latency relative to hc/vc, so sync and colour remain aligned.
REQ-031 If pix_en is held low, the counters and all outputs SHALL hold their values.

Reset
REQ-032 While rst=1 at a clk edge:
- hc=0, vc=0
- hsync=1, vsync=1
- RGB=0, frame_start=0
- shadow cells=0, shadow cursor=15
REQ-033 Reset SHALL take priority over pix_en; reset mid-frame restarts timing at hc=0, vc=0 on the next pix_en.

Structure
REQ-034 A shared package vga_pkg SHALL hold the 640×480 timing defaults, the cell encodings EMPTY/X/O and the 8-bit colour constants.
REQ-035 One sub-module, vga_timing, SHALL produce hc, vc, raw sync, active and wrap strobes; vga_grid_display SHALL contain the grid, shadow and pixel-pipeline logic.

Verification
REQ-036 Scenario: reset, then 800×521 pix_en strobes. Required: one hsync low run of 96 pixels per line, one vsync low run of 2 lines per frame, and frame_start pulsing exactly once per frame.
REQ-037 Scenario: cells=0, cursor=15; sample x=230..239 at y=50 (col 0 line). Required: white. x=240 at the same y: black. y=150: white, for the row 0 line.
REQ-038 Scenario: cells[1:0]=01, then sample (x=150, y=60). Required: red. cells[3:2]=10, then sample (x=310, y=60): blue.
REQ-039 Scenario: cursor=4 with cell 4 empty; sample (x=300, y=220). Required: yellow. Then set cell 4=01; the same pixel stays yellow until the next frame boundary, and is red afterwards.
REQ-040 Scenario: assert rst for 1 clk while hc=400, vc=200. Required: next outputs are hsync=1, vsync=1, RGB=0, and counting restarts from 0,0.
REQ-041 Scenario: pix_en held low for 50 clks. Required: hc, vc and all outputs unchanged.
